// File: rtl/demux1_5_stage_if.sv
// Handshake bundle for the 1-to-5 demultiplexing stage: one upstream producer port,
// five downstream lanes, and the bad-select reporting outputs.
interface demux1_5_stage_if #(
    parameter int DW = 16,
    parameter int CW = 8
);
    logic [DW-1:0]   in_data;
    logic [2:0]      in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [5*DW-1:0] out_data;
    logic [4:0]      out_valid;
    logic [4:0]      out_ready;
    logic            err_pulse;
    logic [CW-1:0]   err_cnt;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err_pulse, err_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, err_pulse, err_cnt
    );
endinterface

// File: rtl/demux1_5_stage.sv
// Registered 1-to-5 demux stage: five independent one-deep lane buffers with valid/ready.
// Optional DEMUX_ERR_CNT_EN compiles in the saturating bad-select counter.
module demux1_5_stage #(
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    demux1_5_stage_if.slave bus
);
    logic [4:0]    valid_q;
    logic [DW-1:0] data_q [5];
    logic          err_q;
    logic [4:0]    sel_hot;
    logic          sel_ok;
    logic          ready;
    logic          accept;

    always_comb begin
        sel_hot = 5'b00000;
        case (bus.in_sel)
            3'd0:    sel_hot = 5'b00001;
            3'd1:    sel_hot = 5'b00010;
            3'd2:    sel_hot = 5'b00100;
            3'd3:    sel_hot = 5'b01000;
            3'd4:    sel_hot = 5'b10000;
            default: sel_hot = 5'b00000;
        endcase
        sel_ok = |sel_hot;
        // Bad selects are always consumed; good ones need room in the target lane.
        ready  = rst_n && (!sel_ok || |(sel_hot & (~valid_q | bus.out_ready)));
        accept = bus.in_valid && ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 5'b00000;
            err_q   <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            err_q <= accept && !sel_ok;
            for (int k = 0; k < 5; k++) begin
                if (accept && sel_hot[k]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= bus.in_data;
                end else if (valid_q[k] && bus.out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX_ERR_CNT_EN
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && !sel_ok && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.err_cnt = cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < 5; k++) begin
            bus.out_data[k*DW +: DW] = data_q[k];
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.err_pulse = err_q;
endmodule

// File: tb/tb_demux1_5_stage.sv
// Directed bench for demux1_5_stage: vector table plus hand sequences for
// streaming, saturation and mid-operation reset.
module tb_demux1_5_stage;
    localparam int DW = 16;
    localparam int CW = 8;
`ifdef DEMUX_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux1_5_stage_if #(.DW(DW), .CW(CW)) bus ();
    demux1_5_stage #(.DW(DW), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic          rst;
        logic          iv;
        logic [2:0]    sel;
        logic [DW-1:0] d;
        logic [4:0]    ordy;
        logic          ir;
        logic [4:0]    ov;
        int            lane;
        logic [DW-1:0] ld;
        logic          ep;
        int            cnt;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic iv, input logic [2:0] sel, input logic [DW-1:0] d,
                       input logic [4:0] ordy, input logic ir, input logic [4:0] ov, input int lane,
                       input logic [DW-1:0] ld, input logic ep, input int cnt);
        vec_t v;
        v.rst = rst; v.iv = iv; v.sel = sel; v.d = d; v.ordy = ordy; v.ir = ir;
        v.ov = ov; v.lane = lane; v.ld = ld; v.ep = ep; v.cnt = cnt;
        vq.push_back(v);
    endtask

    function automatic logic [DW-1:0] lane_of(input int k);
        return bus.out_data[k*DW +: DW];
    endfunction

    function automatic int exp_cnt(input int c);
        return CNT_ON ? c : 0;
    endfunction

    task automatic drive(input logic rst, input logic iv, input logic [2:0] sel,
                         input logic [DW-1:0] d, input logic [4:0] ordy);
        rst_n = rst; bus.in_valid = iv; bus.in_sel = sel; bus.in_data = d; bus.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt_model;
        drive(1'b0, 1'b1, 3'd0, 16'd400, 5'b00000);

        // rst iv sel data ordy | in_ready out_valid lane lane_data err_pulse err_cnt
        add(0, 1, 3'd0, 16'd400,  5'b00000, 0, 5'b00000, 0, 16'd0,    0, 0);
        add(0, 1, 3'd5, 16'd974,  5'b11111, 0, 5'b00000, 1, 16'd0,    0, 0);
        add(0, 1, 3'd2, 16'd1024, 5'b00000, 0, 5'b00000, 2, 16'd0,    0, 0);
        add(1, 1, 3'd0, 16'd400,  5'b00000, 1, 5'b00001, 0, 16'd400,  0, 0);
        add(1, 1, 3'd1, 16'd974,  5'b00000, 1, 5'b00011, 1, 16'd974,  0, 0);
        add(1, 1, 3'd2, 16'd1024, 5'b00000, 1, 5'b00111, 2, 16'd1024, 0, 0);
        add(1, 1, 3'd3, 16'd2059, 5'b00000, 1, 5'b01111, 3, 16'd2059, 0, 0);
        add(1, 1, 3'd4, 16'd4097, 5'b00000, 1, 5'b11111, 4, 16'd4097, 0, 0);
        add(1, 1, 3'd2, 16'd555,  5'b00000, 0, 5'b11111, 2, 16'd1024, 0, 0);
        add(1, 1, 3'd2, 16'd555,  5'b00100, 1, 5'b11111, 2, 16'd555,  0, 0);
        add(1, 1, 3'd5, 16'd4097, 5'b00000, 1, 5'b11111, 4, 16'd4097, 1, 1);
        add(1, 1, 3'd7, 16'd4097, 5'b00000, 1, 5'b11111, 2, 16'd555,  1, 2);
        add(1, 0, 3'd0, 16'd9,    5'b00000, 0, 5'b11111, 0, 16'd400,  0, 2);
        add(1, 0, 3'd0, 16'd9,    5'b11111, 1, 5'b00000, 0, 16'd400,  0, 2);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].iv, vq[i].sel, vq[i].d, vq[i].ordy);
            #1;
            chk($sformatf("v%0d in_ready", i), bus.in_ready, vq[i].ir);
            step();
            chk($sformatf("v%0d out_valid", i), bus.out_valid, vq[i].ov);
            chk($sformatf("v%0d lane%0d data", i, vq[i].lane), lane_of(vq[i].lane), vq[i].ld);
            chk($sformatf("v%0d err_pulse", i), bus.err_pulse, vq[i].ep);
            chk($sformatf("v%0d err_cnt", i), bus.err_cnt, exp_cnt(vq[i].cnt));
        end

        // Lane 0 stalled while lane 3 streams at full rate.
        drive(1'b1, 1'b1, 3'd0, 16'd77, 5'b00000);
        step();
        chk("indep lane0 load", lane_of(0), 16'd77);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 3'd3, 16'(100 + i), 5'b01000);
            #1;
            chk($sformatf("stream%0d in_ready", i), bus.in_ready, 1'b1);
            step();
            chk($sformatf("stream%0d out_valid", i), bus.out_valid, 5'b01001);
            chk($sformatf("stream%0d lane3", i), lane_of(3), 16'(100 + i));
            chk($sformatf("stream%0d lane0", i), lane_of(0), 16'd77);
        end
        drive(1'b1, 1'b0, 3'd3, 16'd0, 5'b01000);
        step();
        chk("stream drain out_valid", bus.out_valid, 5'b00001);

        // Saturation: 260 more bad selects on top of the two already counted.
        cnt_model = 2;
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 1'b1, 3'd6, 16'(i), 5'b00000);
            step();
            if (cnt_model < 255) cnt_model++;
            chk($sformatf("sat%0d err_pulse", i), bus.err_pulse, 1'b1);
            chk($sformatf("sat%0d err_cnt", i), bus.err_cnt, exp_cnt(cnt_model));
        end
        chk("sat out_valid", bus.out_valid, 5'b00001);
        drive(1'b1, 1'b0, 3'd6, 16'd0, 5'b00000);
        step();
        chk("sat end err_pulse", bus.err_pulse, 1'b0);
        chk("sat end err_cnt", bus.err_cnt, exp_cnt(255));

        // Mid-operation reset discards held words and the counter.
        drive(1'b1, 1'b1, 3'd1, 16'd321, 5'b00000);
        step();
        chk("pre-reset out_valid", bus.out_valid, 5'b00011);
        drive(1'b0, 1'b1, 3'd6, 16'd5, 5'b00000);
        #1;
        chk("mid reset in_ready", bus.in_ready, 1'b0);
        step();
        chk("mid reset out_valid", bus.out_valid, 5'b00000);
        chk("mid reset lane0", lane_of(0), 16'd0);
        chk("mid reset lane1", lane_of(1), 16'd0);
        chk("mid reset err_pulse", bus.err_pulse, 1'b0);
        chk("mid reset err_cnt", bus.err_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
